// File: rtl/asym_fifo_ctrl_pkg.sv
// Shared sizing and payload types for the width-converting FIFO controller
// and its asymmetric RAM.
package asym_fifo_ctrl_pkg;

    localparam int unsigned WIDTHA  = 384;
    localparam int unsigned WIDTHB  = 48;
    localparam int unsigned DEPTHA  = 128;
    localparam int unsigned RATIO   = WIDTHA / WIDTHB;
    localparam int unsigned RATIO_W = $clog2(RATIO);
    localparam int unsigned AW_A    = $clog2(DEPTHA);
    localparam int unsigned AW_B    = AW_A + RATIO_W;
    localparam int unsigned LU_W    = AW_A + 1;

    typedef logic [WIDTHA-1:0] line_t;
    typedef logic [WIDTHB-1:0] elem_t;

    // True when a narrow read address selects the last slice of its line.
    function automatic logic is_last_slice(input logic [AW_B-1:0] addr);
        return addr[RATIO_W-1:0] == RATIO_W'(RATIO - 1);
    endfunction

endpackage

// File: rtl/asym_ram.sv
// Dual-port RAM with a wide write port and a narrow synchronous read port;
// narrow address = {line, slice}, slice 0 is the low bits of the line.
module asym_ram
    import asym_fifo_ctrl_pkg::*;
(
    input  logic            clk_a_i,
    input  logic            we_a_i,
    input  logic [AW_A-1:0] addr_a_i,
    input  line_t           din_a_i,
    input  logic            clk_b_i,
    input  logic [AW_B-1:0] addr_b_i,
    output elem_t           dout_b_o
);

    logic [RATIO-1:0][WIDTHB-1:0] mem_q [DEPTHA];
    elem_t                        dout_q;

    always_ff @(posedge clk_a_i) begin
        if (we_a_i) begin
            mem_q[addr_a_i] <= din_a_i;
        end
    end

    always_ff @(posedge clk_b_i) begin
        dout_q <= mem_q[addr_b_i[AW_B-1:RATIO_W]][addr_b_i[RATIO_W-1:0]];
    end

    assign dout_b_o = dout_q;

endmodule

// File: rtl/asym_fifo_ctrl.sv
// Line-in / element-out FIFO controller: writes wide lines into asym_ram and
// replays them slice by slice through a 2-entry output buffer.
module asym_fifo_ctrl
    import asym_fifo_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  line_t           in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output elem_t           out_data,
    input  logic            flush,
    output logic [LU_W-1:0] lines_used,
    output logic            empty
);

    logic [AW_A-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW_B-1:0] rd_ptr_q, rd_ptr_d;
    logic [LU_W-1:0] lu_q, lu_d;
    logic            inflight_q, inflight_d;
    logic [1:0]      cnt_q, cnt_d;
    elem_t           head_q, head_d;
    elem_t           tail_q, tail_d;
    logic            rdy_en_q;
    elem_t           ram_dout;

    logic accept, pop, credit, issue, line_free, push;

    asym_ram u_ram (
        .clk_a_i  (clk),
        .we_a_i   (accept),
        .addr_a_i (wr_ptr_q),
        .din_a_i  (in_data),
        .clk_b_i  (clk),
        .addr_b_i (rd_ptr_q),
        .dout_b_o (ram_dout)
    );

    assign in_ready   = rdy_en_q & (lu_q < LU_W'(DEPTHA)) & ~flush;
    assign accept     = in_valid & in_ready;
    assign out_valid  = cnt_q != 2'd0;
    assign pop        = out_valid & out_ready;
    // Buffered plus in-flight elements never exceed the two buffer slots.
    assign credit     = (({1'b0, cnt_q} + {2'b00, inflight_q}) < 3'd2) | pop;
    assign issue      = (lu_q != '0) & credit & ~flush;
    assign line_free  = issue & is_last_slice(rd_ptr_q);
    assign push       = inflight_q;
    assign out_data   = head_q;
    assign lines_used = lu_q;
    assign empty      = (lu_q == '0) & ~inflight_q & (cnt_q == 2'd0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lu_d       = lu_q;
        inflight_d = issue;
        cnt_d      = cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (accept) wr_ptr_d = wr_ptr_q + AW_A'(1);
        if (issue)  rd_ptr_d = rd_ptr_q + AW_B'(1);

        case ({accept, line_free})
            2'b10:   lu_d = lu_q + LU_W'(1);
            2'b01:   lu_d = lu_q - LU_W'(1);
            default: lu_d = lu_q;
        endcase

        // Output buffer: head_q is always the element presented on out_data.
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = ram_dout;
                    cnt_d  = 2'd1;
                end else begin
                    tail_d = ram_dout;
                    cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = ram_dout;
                end else begin
                    head_d = tail_q;
                    tail_d = ram_dout;
                end
            end
            default: cnt_d = cnt_q;
        endcase

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            lu_d       = '0;
            inflight_d = 1'b0;
            cnt_d      = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lu_q       <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lu_q       <= lu_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            rdy_en_q   <= 1'b1;
        end
    end

endmodule

// File: doc/asym_fifo_ctrl.md
# asym_fifo_ctrl

Single-clock width-converting FIFO controller built around the `asym_ram` block: it accepts 384-bit lines on a valid/ready stream, writes them through the RAM's wide port, and replays them as 48-bit elements, lowest slice first, on a narrow valid/ready stream. It owns the pointers, occupancy, back-pressure and read-latency compensation, so pair-HMM consumers see a plain FIFO. Sits between the host-facing line fetch and the element-wise compute pipeline.

## Interface
- WIDTHA, 384, input line width
- WIDTHB, 48, output element width; RATIO = WIDTHA/WIDTHB = 8, power of two
- DEPTHA, 128, capacity in lines; power of two
- clk  in  1  clock; both RAM ports run on it
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  line offered
- in_ready  out  1  line accepted when in_valid & in_ready
- in_data  in  WIDTHA  line; element 0 = bits [WIDTHB-1:0]
- out_valid  out  1  element available
- out_ready  in  1  element consumed when out_valid & out_ready
- out_data  out  WIDTHB  element
- flush  in  1  synchronous clear of all contents
- lines_used  out  log2(DEPTHA)+1  lines not yet fully read-issued
- empty  out  1  lines_used==0 and nothing in flight or buffered

## Operation
- Write: on accept, write in_data at wr_ptr (log2(DEPTHA) bits, wraps), wr_ptr+1, lines_used+1.
- in_ready = (lines_used < DEPTHA) & ~flush; no combinational path from in_valid.
- Read issue: rd_ptr (log2(DEPTHA*RATIO) bits, wraps) drives the narrow address. Issue when lines_used>0 & credit; rd_ptr+1. When rd_ptr low log2(RATIO) bits == RATIO-1 at issue, lines_used-1 (line freed).
- Simultaneous accept and line free: lines_used unchanged.
- Credit: 2-entry output FIFO; issue allowed when (ofifo_count + inflight < 2) or (out_valid & out_ready). Sustains 1 element/cycle.
- inflight: 1-bit flag, set on issue; cleared the next cycle when the RAM output is pushed into the output FIFO.
- out_valid = ofifo_count>0; out_data = ofifo head (registered, not RAM output).
- A freed line may be rewritten from the cycle after its last slice issues; RAM captures the read data on the issue edge, so no overwrite hazard.
- Full: lines_used==DEPTHA → in_ready=0 until a line frees. Empty: no issue; out_valid falls once ofifo drains.
- flush (1 cycle): next edge clears wr_ptr, rd_ptr, lines_used, inflight, ofifo_count; discards any concurrent accept and issue; RAM contents not cleared.

## Timing
- Reset (rst_n=0, any time, mid-transfer included): in_ready=0 while asserted, 1 from first cycle after release; out_valid=0, out_data=0, lines_used=0, empty=1; all pointers 0.
- Latency: line accepted at edge 0 → issue in cycle 1 → RAM data cycle 2 → pushed at edge 2 → out_valid=1 in cycle 3 with element 0.
- Throughput: 1 line/cycle in (until full), 1 element/cycle out; a line drains in RATIO cycles.
- out_valid never drops without a pop; out_data stable while out_valid & ~out_ready.

## Structure
- Shared package: WIDTHA/WIDTHB/DEPTHA defaults, RATIO and log2 helpers, element/line typedefs.
- Sub-module: one `asym_ram` instance (clkA=clkB=clk, weA=accept, addrA=wr_ptr, addrB=rd_ptr); output FIFO and counters inline.

## Test plan
- Reset then one line 0x…_0007_0006_…_0000 (element i = i) with out_ready=1 → out_valid from cycle 3, out_data 0..7 on 8 consecutive cycles, then empty=1.
- Write 128 lines, out_ready=0 → lines_used=128, in_ready=0; one pop sequence of 8 → in_ready=1 the cycle after 8th slice issues.
- Continuous in/out with out_ready toggled pseudo-randomly over 1000 lines → data order exact, no loss/duplication, pointers wrap at 128/1024.
- out_ready=0 for 5 cycles mid-line → out_data held, ofifo_count ≤2, resumes with next element.
- flush with 3 lines stored and read in flight → next cycle lines_used=0, out_valid=0, empty=1; next written line reads back correctly.
- rst_n pulsed low mid-stream asynchronously → outputs reach reset values immediately, normal operation after release.
